// File: rtl/decode_stage.sv
// RV32I DECODE stage: drives the register-file read port, decodes the fetched
// instruction and registers control/immediate/addresses into ID/EX. A sticky
// halt FSM stops issue after ecall, ebreak or an illegal instruction.
module decode_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_valid_i,
    input  logic [31:0] if_pc_i,
    input  logic [31:0] if_instr_i,
    input  logic        id_stall_i,
    input  logic        id_flush_i,
    output logic        rs_rd_en_o,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o,
    output logic        ex_valid_o,
    output logic [31:0] ex_pc_o,
    output logic [4:0]  ex_rd_o,
    output logic [4:0]  ex_rs1_o,
    output logic [4:0]  ex_rs2_o,
    output logic [31:0] ex_imm_o,
    output logic [3:0]  ex_alu_op_o,
    output logic        ex_alu_src_imm_o,
    output logic        ex_alu_src_pc_o,
    output logic        ex_mem_rd_o,
    output logic        ex_mem_wr_o,
    output logic [2:0]  ex_mem_size_o,
    output logic        ex_rd_wr_en_o,
    output logic [1:0]  ex_wb_sel_o,
    output logic        ex_branch_o,
    output logic        ex_jal_o,
    output logic        ex_jalr_o,
    output logic        ex_illegal_o,
    output logic        ex_halt_o,
    output logic        halted_o
);

    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcFence  = 7'b0001111;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcSystem = 7'b1110011;

    localparam logic [3:0] AluAdd   = 4'd0;
    localparam logic [3:0] AluSub   = 4'd1;
    localparam logic [3:0] AluSll   = 4'd2;
    localparam logic [3:0] AluSlt   = 4'd3;
    localparam logic [3:0] AluSltu  = 4'd4;
    localparam logic [3:0] AluXor   = 4'd5;
    localparam logic [3:0] AluSrl   = 4'd6;
    localparam logic [3:0] AluSra   = 4'd7;
    localparam logic [3:0] AluOr    = 4'd8;
    localparam logic [3:0] AluAnd   = 4'd9;
    localparam logic [3:0] AluPassB = 4'd10;

    localparam logic [1:0] WbAlu = 2'd0;
    localparam logic [1:0] WbMem = 2'd1;
    localparam logic [1:0] WbPc4 = 2'd2;

    typedef enum logic {StRun, StHalt} state_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [3:0]  alu_op;
        logic        src_imm;
        logic        src_pc;
        logic        mem_rd;
        logic        mem_wr;
        logic [2:0]  mem_size;
        logic        rd_wr_en;
        logic [1:0]  wb_sel;
        logic        branch;
        logic        jal;
        logic        jalr;
        logic        illegal;
        logic        halt;
    } idex_t;

    state_e state_q, state_d;
    idex_t  idex_q, idex_d;
    idex_t  raw, dec;
    logic   illegal;
    logic   alt;
    logic [3:0] alu_fn;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        f7_zero;
    logic        f7_alt;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode  = if_instr_i[6:0];
    assign funct3  = if_instr_i[14:12];
    assign funct7  = if_instr_i[31:25];
    assign f7_zero = (funct7 == 7'b0000000);
    assign f7_alt  = (funct7 == 7'b0100000);

    assign imm_i = {{20{if_instr_i[31]}}, if_instr_i[31:20]};
    assign imm_s = {{20{if_instr_i[31]}}, if_instr_i[31:25], if_instr_i[11:7]};
    assign imm_b = {{19{if_instr_i[31]}}, if_instr_i[31], if_instr_i[7],
                    if_instr_i[30:25], if_instr_i[11:8], 1'b0};
    assign imm_u = {if_instr_i[31:12], 12'd0};
    assign imm_j = {{11{if_instr_i[31]}}, if_instr_i[31], if_instr_i[19:12],
                    if_instr_i[20], if_instr_i[30:21], 1'b0};

    assign rs1_o = if_instr_i[19:15];
    assign rs2_o = if_instr_i[24:20];

    // ALU function from funct3; the funct7 alternate bit only matters for OP and shift-right imm
    always_comb begin
        alt    = f7_alt && ((opcode == OpcOp) || (funct3 == 3'b101));
        alu_fn = AluAdd;
        case (funct3)
            3'b000:  alu_fn = alt ? AluSub : AluAdd;
            3'b001:  alu_fn = AluSll;
            3'b010:  alu_fn = AluSlt;
            3'b011:  alu_fn = AluSltu;
            3'b100:  alu_fn = AluXor;
            3'b101:  alu_fn = alt ? AluSra : AluSrl;
            3'b110:  alu_fn = AluOr;
            default: alu_fn = AluAnd;
        endcase
    end

    // Decode the instruction word into ID/EX form, gating controls on illegal or invalid
    always_comb begin
        raw       = '0;
        raw.valid = if_valid_i;
        raw.pc    = if_pc_i;
        raw.rd    = if_instr_i[11:7];
        raw.rs1   = if_instr_i[19:15];
        raw.rs2   = if_instr_i[24:20];
        illegal   = 1'b0;
        case (opcode)
            OpcOp: begin
                raw.alu_op   = alu_fn;
                raw.rd_wr_en = 1'b1;
                raw.wb_sel   = WbAlu;
                illegal = !(f7_zero || (f7_alt && ((funct3 == 3'b000) || (funct3 == 3'b101))));
            end
            OpcOpImm: begin
                raw.imm      = imm_i;
                raw.alu_op   = alu_fn;
                raw.src_imm  = 1'b1;
                raw.rd_wr_en = 1'b1;
                raw.wb_sel   = WbAlu;
                illegal = ((funct3 == 3'b001) && !f7_zero) ||
                          ((funct3 == 3'b101) && !f7_zero && !f7_alt);
            end
            OpcLui: begin
                raw.imm      = imm_u;
                raw.alu_op   = AluPassB;
                raw.src_imm  = 1'b1;
                raw.rd_wr_en = 1'b1;
            end
            OpcAuipc: begin
                raw.imm      = imm_u;
                raw.alu_op   = AluAdd;
                raw.src_pc   = 1'b1;
                raw.src_imm  = 1'b1;
                raw.rd_wr_en = 1'b1;
            end
            OpcJal: begin
                raw.imm      = imm_j;
                raw.alu_op   = AluAdd;
                raw.src_pc   = 1'b1;
                raw.src_imm  = 1'b1;
                raw.rd_wr_en = 1'b1;
                raw.wb_sel   = WbPc4;
                raw.jal      = 1'b1;
            end
            OpcJalr: begin
                raw.imm      = imm_i;
                raw.alu_op   = AluAdd;
                raw.src_imm  = 1'b1;
                raw.rd_wr_en = 1'b1;
                raw.wb_sel   = WbPc4;
                raw.jalr     = 1'b1;
                illegal      = (funct3 != 3'b000);
            end
            OpcBranch: begin
                raw.imm      = imm_b;
                raw.alu_op   = AluSub;
                raw.branch   = 1'b1;
                raw.mem_size = funct3;
                illegal      = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OpcLoad: begin
                raw.imm      = imm_i;
                raw.alu_op   = AluAdd;
                raw.src_imm  = 1'b1;
                raw.mem_rd   = 1'b1;
                raw.mem_size = funct3;
                raw.rd_wr_en = 1'b1;
                raw.wb_sel   = WbMem;
                illegal      = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            OpcStore: begin
                raw.imm      = imm_s;
                raw.alu_op   = AluAdd;
                raw.src_imm  = 1'b1;
                raw.mem_wr   = 1'b1;
                raw.mem_size = funct3;
                illegal      = (funct3[2] == 1'b1) || (funct3 == 3'b011);
            end
            OpcFence: begin
                raw.alu_op = AluAdd;
            end
            OpcSystem: begin
                if ((if_instr_i == 32'h0000_0073) || (if_instr_i == 32'h0010_0073)) begin
                    raw.halt = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            default: illegal = 1'b1;
        endcase

        dec = raw;
        // Illegal or invalid slots keep their data fields but lose every control bit
        if (illegal || !if_valid_i) begin
            dec         = '0;
            dec.valid   = raw.valid;
            dec.pc      = raw.pc;
            dec.rd      = raw.rd;
            dec.rs1     = raw.rs1;
            dec.rs2     = raw.rs2;
            dec.imm     = raw.imm;
            dec.illegal = illegal && if_valid_i;
        end
        if (raw.rd == 5'd0) begin
            dec.rd_wr_en = 1'b0;
        end
    end

    // ID/EX next state: flush beats stall beats halt-bubble beats load
    always_comb begin
        idex_d = idex_q;
        if (id_flush_i) begin
            idex_d = '0;
        end else if (id_stall_i) begin
            idex_d = idex_q;
        end else if (state_q == StHalt) begin
            idex_d = '0;
        end else begin
            idex_d = dec;
        end
    end

    // ID/EX pipeline register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    // Halt FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    // Halt FSM next state and read-port/halt outputs
    always_comb begin
        state_d    = state_q;
        rs_rd_en_o = 1'b0;
        halted_o   = 1'b0;
        case (state_q)
            StRun: begin
                rs_rd_en_o = !id_stall_i;
                if (!id_flush_i && !id_stall_i && dec.valid && (dec.halt || dec.illegal)) begin
                    state_d = StHalt;
                end
            end
            default: begin
                halted_o = 1'b1;
            end
        endcase
    end

    assign ex_valid_o       = idex_q.valid;
    assign ex_pc_o          = idex_q.pc;
    assign ex_rd_o          = idex_q.rd;
    assign ex_rs1_o         = idex_q.rs1;
    assign ex_rs2_o         = idex_q.rs2;
    assign ex_imm_o         = idex_q.imm;
    assign ex_alu_op_o      = idex_q.alu_op;
    assign ex_alu_src_imm_o = idex_q.src_imm;
    assign ex_alu_src_pc_o  = idex_q.src_pc;
    assign ex_mem_rd_o      = idex_q.mem_rd;
    assign ex_mem_wr_o      = idex_q.mem_wr;
    assign ex_mem_size_o    = idex_q.mem_size;
    assign ex_rd_wr_en_o    = idex_q.rd_wr_en;
    assign ex_wb_sel_o      = idex_q.wb_sel;
    assign ex_branch_o      = idex_q.branch;
    assign ex_jal_o         = idex_q.jal;
    assign ex_jalr_o        = idex_q.jalr;
    assign ex_illegal_o     = idex_q.illegal;
    assign ex_halt_o        = idex_q.halt;

endmodule
